// File: rtl/mips_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : mips_regfile_sb
// Brief    : MIPS register file, NUM_RD read ports, write-to-read bypass and
//            per-register pending-write scoreboard for RAW hazard detection.
//            Optional: MIPS_REGFILE_R0_ZERO_EN hardwires R0 to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mips_regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int CNT_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
   output logic [NUM_RD*DATA_W-1:0] rd_data_o,
   output logic [NUM_RD-1:0]        rd_busy_o,
   input  logic                     wr_en_i,
   input  logic [ADDR_W-1:0]        wr_addr_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     iss_en_i,
   input  logic [ADDR_W-1:0]        iss_addr_i,
   output logic                     iss_rdy_o
);

   localparam int               C_DEPTH   = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] regs_q [C_DEPTH];
   logic [CNT_W-1:0]  cnt_q  [C_DEPTH];
   logic [CNT_W-1:0]  cnt_d  [C_DEPTH];

   logic w_iss_wr_hit;
   logic w_iss_acc;
   logic w_wr_ok;

   assign w_iss_wr_hit = wr_en_i && (wr_addr_i == iss_addr_i);

`ifdef MIPS_REGFILE_R0_ZERO_EN
   assign iss_rdy_o = (cnt_q[iss_addr_i] != C_CNT_MAX) || w_iss_wr_hit ||
                      (iss_addr_i == '0);
   assign w_iss_acc = iss_en_i && iss_rdy_o && (iss_addr_i != '0);
   assign w_wr_ok   = wr_en_i && (wr_addr_i != '0);
`else
   assign iss_rdy_o = (cnt_q[iss_addr_i] != C_CNT_MAX) || w_iss_wr_hit;
   assign w_iss_acc = iss_en_i && iss_rdy_o;
   assign w_wr_ok   = wr_en_i;
`endif

   // Issue and writeback to the same register cancel out; decrement floors at 0.
   always_comb begin
      for (int r = 0; r < C_DEPTH; r++) begin
         cnt_d[r] = cnt_q[r];
      end
      if (w_iss_acc && !(w_wr_ok && (wr_addr_i == iss_addr_i))) begin
         cnt_d[iss_addr_i] = cnt_q[iss_addr_i] + C_CNT_ONE;
      end
      if (w_wr_ok && !(w_iss_acc && (iss_addr_i == wr_addr_i)) &&
          (cnt_q[wr_addr_i] != '0)) begin
         cnt_d[wr_addr_i] = cnt_q[wr_addr_i] - C_CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < C_DEPTH; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
      end else begin
         for (int r = 0; r < C_DEPTH; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         if (w_wr_ok) begin
            regs_q[wr_addr_i] <= wr_data_i;
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] w_a;
      logic              w_hit;

      assign w_a   = rd_addr_i[i*ADDR_W +: ADDR_W];
      assign w_hit = wr_en_i && (wr_addr_i == w_a);

      always_comb begin
         rd_data_o[i*DATA_W +: DATA_W] = w_hit ? wr_data_i : regs_q[w_a];
         // A final writeback landing this cycle clears busy; bypass supplies data.
         rd_busy_o[i] = (cnt_q[w_a] != '0) && !(w_hit && (cnt_q[w_a] == C_CNT_ONE));
`ifdef MIPS_REGFILE_R0_ZERO_EN
         if (w_a == '0) begin
            rd_data_o[i*DATA_W +: DATA_W] = '0;
            rd_busy_o[i]                  = 1'b0;
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_regfile_sb
// Brief    : Directed vector bench for mips_regfile_sb (DATA_W=32, NUM_RD=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_regfile_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int CNT_W  = 2;
`ifdef MIPS_REGFILE_R0_ZERO_EN
   localparam bit R0Z = 1'b1;
`else
   localparam bit R0Z = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     iss_rdy;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mips_regfile_sb #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .iss_en_i(iss_en), .iss_addr_i(iss_addr), .iss_rdy_o(iss_rdy)
   );

   typedef struct {
      logic              rst;
      logic              wr_en;
      logic [ADDR_W-1:0] wr_addr;
      logic [DATA_W-1:0] wr_data;
      logic              iss_en;
      logic [ADDR_W-1:0] iss_addr;
      logic [ADDR_W-1:0] ra0;
      logic [ADDR_W-1:0] ra1;
      logic [DATA_W-1:0] d0;
      logic [DATA_W-1:0] d1;
      logic [1:0]        busy;
      logic              rdy;
   } vec_t;

   vec_t tbl[$];

   // Drive one cycle at the falling edge, check combinational outputs 1 ns later.
   task automatic apply(input vec_t v, input string name);
      @(negedge clk);
      rst      = v.rst;
      wr_en    = v.wr_en;
      wr_addr  = v.wr_addr;
      wr_data  = v.wr_data;
      iss_en   = v.iss_en;
      iss_addr = v.iss_addr;
      rd_addr  = {v.ra1, v.ra0};
      #1;
      n_vec++;
      if (rd_data !== {v.d1, v.d0} || rd_busy !== v.busy || iss_rdy !== v.rdy) begin
         n_bad++;
         $display("FAIL %s: got data=%h_%h busy=%b rdy=%b, want data=%h_%h busy=%b rdy=%b",
                  name, rd_data[63:32], rd_data[31:0], rd_busy, iss_rdy,
                  v.d1, v.d0, v.busy, v.rdy);
      end
   endtask

   task automatic add(input logic r, input logic we, input int wa, input int wd,
                      input logic ie, input int ia, input int a0, input int a1,
                      input int e0, input int e1, input logic [1:0] eb, input logic er);
      vec_t v;
      v.rst = r; v.wr_en = we; v.wr_addr = ADDR_W'(wa); v.wr_data = DATA_W'(wd);
      v.iss_en = ie; v.iss_addr = ADDR_W'(ia);
      v.ra0 = ADDR_W'(a0); v.ra1 = ADDR_W'(a1);
      v.d0 = DATA_W'(e0); v.d1 = DATA_W'(e1); v.busy = eb; v.rdy = er;
      tbl.push_back(v);
   endtask

   initial begin
      vec_t v;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
      repeat (2) @(negedge clk);

      // Post-reset sweep of every register on both ports.
      for (int i = 0; i < 32; i++) begin
         v = '{rst:1'b0, wr_en:1'b0, wr_addr:'0, wr_data:'0, iss_en:1'b0,
               iss_addr:ADDR_W'(i), ra0:ADDR_W'(i), ra1:ADDR_W'(31 - i),
               d0:'0, d1:'0, busy:2'b00, rdy:1'b1};
         apply(v, "reset_sweep");
      end

      //   rst we wa wd  ie ia a0 a1  e0  e1  busy   rdy
      // bypass then array read
      add(0, 1, 21, 31, 0, 0, 21, 0, 31, 0, 2'b00, 1);
      add(0, 0, 0, 0,   0, 0, 21, 0, 31, 0, 2'b00, 1);
      // issue 21, final writeback clears busy in the same cycle
      add(0, 0, 0, 0,   1, 21, 21, 0, 31, 0, 2'b00, 1);
      add(0, 0, 0, 0,   0, 0, 21, 0, 31, 0, 2'b01, 1);
      add(0, 0, 0, 0,   0, 0, 21, 0, 31, 0, 2'b01, 1);
      add(0, 1, 21, 7,  0, 0, 21, 21, 7, 7, 2'b00, 1);
      add(0, 0, 0, 0,   0, 0, 21, 21, 7, 7, 2'b00, 1);
      // saturate counter of 20
      add(0, 0, 0, 0,   1, 20, 20, 0, 0, 0, 2'b00, 1);
      add(0, 0, 0, 0,   1, 20, 20, 0, 0, 0, 2'b01, 1);
      add(0, 0, 0, 0,   1, 20, 20, 0, 0, 0, 2'b01, 1);
      add(0, 0, 0, 0,   1, 20, 20, 0, 0, 0, 2'b01, 0);
      add(0, 0, 0, 0,   0, 20, 20, 0, 0, 0, 2'b01, 0);
      add(0, 1, 20, 5,  1, 20, 20, 0, 5, 0, 2'b01, 1);
      add(0, 0, 0, 0,   0, 20, 20, 0, 5, 0, 2'b01, 0);
      add(0, 1, 20, 6,  0, 20, 20, 0, 6, 0, 2'b01, 1);
      add(0, 1, 20, 8,  0, 20, 20, 0, 8, 0, 2'b01, 1);
      add(0, 1, 20, 9,  0, 20, 20, 0, 9, 0, 2'b00, 1);
      add(0, 0, 0, 0,   0, 20, 20, 0, 9, 0, 2'b00, 1);
      // reset mid-operation drops pending counts and the in-flight write
      add(0, 1, 31, 31, 0, 0, 31, 0, 31, 0, 2'b00, 1);
      add(0, 0, 0, 0,   1, 31, 31, 0, 31, 0, 2'b00, 1);
      add(0, 0, 0, 0,   1, 31, 31, 0, 31, 0, 2'b01, 1);
      add(1, 1, 31, 99, 0, 0, 31, 0, 99, 0, 2'b01, 1);
      add(0, 0, 0, 0,   0, 31, 31, 20, 0, 0, 2'b00, 1);
      // R0 behaviour
      add(0, 1, 0, 1,   0, 0, 0, 0, R0Z ? 0 : 1, R0Z ? 0 : 1, 2'b00, 1);
      add(0, 0, 0, 0,   0, 0, 0, 0, R0Z ? 0 : 1, R0Z ? 0 : 1, 2'b00, 1);
      add(0, 0, 0, 0,   1, 0, 0, 0, R0Z ? 0 : 1, R0Z ? 0 : 1, 2'b00, 1);
      add(0, 0, 0, 0,   0, 0, 0, 0, R0Z ? 0 : 1, R0Z ? 0 : 1, R0Z ? 2'b00 : 2'b11, 1);
      // issue and write to different registers in the same cycle
      add(0, 1, 0, 2,   1, 5, 0, 5, R0Z ? 0 : 2, 0, 2'b00, 1);
      add(0, 0, 0, 0,   0, 0, 0, 5, R0Z ? 0 : 2, 0, 2'b10, 1);
      // writeback with no pending issue must not underflow
      add(0, 1, 7, 3,   0, 7, 7, 0, 3, R0Z ? 0 : 2, 2'b00, 1);
      add(0, 0, 0, 0,   1, 7, 7, 0, 3, R0Z ? 0 : 2, 2'b00, 1);
      add(0, 0, 0, 0,   0, 7, 7, 0, 3, R0Z ? 0 : 2, 2'b01, 1);

      foreach (tbl[k]) begin
         apply(tbl[k], $sformatf("vec%0d", k));
      end

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
- Parametrised successor to the current mips32 register file: NUM_RD combinational read ports, one write port, and write-to-read bypass.
- Adds a per-register pending-write scoreboard so the decode stage detects RAW hazards without comparing pipeline-register fields.
- Sits between ID (reads, issue marking) and WB (writeback).
- Replaces direct register-file accesses inside mips32.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (>=1)
- CNT_W, 2, width of per-register outstanding-write counter; max outstanding = 2**CNT_W-1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data, same packing
- rd_busy  output  NUM_RD  1 = register on port i has an uncommitted producer
- wr_en  input  1  writeback strobe
- wr_addr  input  ADDR_W  writeback index
- wr_data  input  DATA_W  writeback data
- iss_en  input  1  instruction issued that will later write iss_addr
- iss_addr  input  ADDR_W  destination of issued instruction
- iss_rdy  output  1  issue accepted; 0 when cnt[iss_addr] is saturated

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst; no asynchronous reset.
- On a clk edge with rst=1:
  - all Reg[] = 0 and all cnt[] = 0;
  - iss_en and wr_en in that cycle are ignored.
- Outputs after reset: rd_data = 0 for any address, rd_busy = 0, iss_rdy = 1.
- Read path (combinational, zero latency):
  - rd_data[i] = wr_data if wr_en && wr_addr == rd_addr[i]; otherwise Reg[rd_addr[i]].
  - Bypass applies independently to every port; ports may alias the same address.
- Write path: Reg[wr_addr] <= wr_data on the clk edge when wr_en=1 and rst=0. The new value is visible through the array on the next cycle.
- Scoreboard counter cnt[r] for each register r, updated on the clk edge:
  - iss accepted (iss_en && iss_rdy) to r, no wr to r: cnt[r] + 1.
  - wr_en to r, no accepted iss to r: cnt[r] - 1, floored at 0 (no underflow; data is still written).
  - accepted iss and wr_en to the same r: cnt unchanged.
  - iss and wr to different registers: both updates apply.
- iss_rdy = (cnt[iss_addr] != 2**CNT_W-1) || (wr_en && wr_addr == iss_addr), combinational. iss_en with iss_rdy=0 has no effect; the issuer must hold the request.
- rd_busy[i] = (cnt[a] != 0) && !(wr_en && wr_addr == a && cnt[a] == 1), where a = rd_addr[i].
  - This means a final writeback in the same cycle clears busy and the bypassed data is used.
  - A same-cycle iss to a does not set rd_busy; busy appears the next cycle.
- Reset mid-operation: all pending counts are discarded; any writeback in flight during the reset cycle is dropped.
- R0 is an ordinary writable register unless the optional feature is enabled.

Optional Feature:
- Macro: MIPS_REGFILE_R0_ZERO_EN.
- Defined:
  - reads of index 0 return 0 with no bypass;
  - writes to 0 are discarded;
  - iss to 0 never increments cnt[0];
  - rd_busy for index 0 is always 0;
  - iss_rdy is always 1 for iss_addr = 0.
- Undefined: R0 behaves like every other register, which is the current mips32 behaviour.

Test Plan:
1. Reset, then read all 32 regs on both ports -> every rd_data = 0, rd_busy = 0, iss_rdy = 1.
2. wr_en, wr_addr=21, wr_data=32'd31, with rd_addr port0=21 in the same cycle -> rd_data0 = 31 combinationally; next cycle with wr_en=0, rd_data0 = 31 from the array.
3. iss 21 at cycle 0 -> rd_busy = 1 from cycle 1. wr 21 = 32'd7 at cycle 3 -> during cycle 3 rd_busy = 0 and rd_data = 7; cycle 4 rd_busy = 0.
4. With CNT_W=2, iss 20 three times -> iss_rdy = 0 for addr 20, and a fourth iss_en is ignored (cnt stays 3). Then iss and wr to 20 in the same cycle -> accepted, cnt stays 3. Three further wr -> rd_busy = 0.
5. Reg[31]=31 with two iss pending on 31 and a wr in progress; assert rst for one cycle -> next cycle Reg[31] = 0, rd_busy = 0, the wr is dropped.
6. Write 32'd1 to R0, then read it -> reads 1 without MIPS_REGFILE_R0_ZERO_EN, reads 0 with it. With the macro, iss to 0 leaves rd_busy = 0.
